// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and helpers for the 1RW SRAM block (parity via SRAM_PARITY_EN)
package sram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest mask lane the parity helper accepts; narrower lanes are zero-extended.
    localparam int LANE_MAX = 64;

    function automatic int num_lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

    function automatic logic lane_parity(input logic [LANE_MAX-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/sram_1rw_array.sv
// rtl/sram_1rw_array.sv - behavioural 1RW storage with OpenRAM-style ports, 1-cycle registered read
module sram_1rw_array #(
    parameter int WORD_WIDTH = 150,
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 512,
    parameter int NUM_LANES  = 5,
    localparam int LANE_WIDTH = WORD_WIDTH / NUM_LANES
) (
    input  logic                  clk0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_LANES-1:0]  wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [WORD_WIDTH-1:0] din0,
    output logic [WORD_WIDTH-1:0] dout0
);

    logic [WORD_WIDTH-1:0] mem [RAM_DEPTH];
    logic                  in_range;

    assign in_range = 32'(addr0) < 32'(RAM_DEPTH);

    // No reset: the real macro has none, contents are zeroed by the controller.
    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                if (in_range) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (wmask0[i]) begin
                            mem[addr0][i*LANE_WIDTH +: LANE_WIDTH] <= din0[i*LANE_WIDTH +: LANE_WIDTH];
                        end
                    end
                end
            end else begin
                dout0 <= in_range ? mem[addr0] : '0;
            end
        end
    end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// rtl/sram_1rw_ctrl.sv - valid/ready SRAM front end with zero-init and 2-entry response buffer (SRAM_PARITY_EN adds lane parity)
module sram_1rw_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 150,
    parameter int ADDR_WIDTH  = 9,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int WMASK_WIDTH = 30,
    localparam int NUM_WMASK  = num_lanes(DATA_WIDTH, WMASK_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASK-1:0]  req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);

`ifdef SRAM_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int LANE_STORE  = WMASK_WIDTH + PAR_BITS;
    localparam int STORE_WIDTH = NUM_WMASK * LANE_STORE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_addr_q;
    logic                    inflight_q;
    logic [1:0]              count_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic                    fifo_err_q  [2];

    logic                    csb, web, accept, pop;
    logic [NUM_WMASK-1:0]    arr_wmask;
    logic [ADDR_WIDTH-1:0]   arr_addr;
    logic [STORE_WIDTH-1:0]  arr_din, arr_dout;
    logic [DATA_WIDTH-1:0]   wr_data, rd_data;
    logic                    rd_err;

    assign rsp_valid = (count_q != 2'd0) || inflight_q;
    assign pop       = rsp_valid && rsp_ready;
    assign init_done = (state_q == ST_RUN);

    // An empty buffer forwards the array output directly, giving 1-cycle read latency.
    assign rsp_rdata = (count_q != 2'd0) ? fifo_data_q[0] : (inflight_q ? rd_data : '0);
    assign rsp_err   = (count_q != 2'd0) ? fifo_err_q[0]  : (inflight_q && rd_err);

    always_comb begin
        state_d   = state_q;
        csb       = 1'b1;
        web       = 1'b1;
        arr_wmask = req_wmask;
        arr_addr  = req_addr;
        wr_data   = req_wdata;
        req_ready = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                csb       = 1'b0;
                web       = 1'b0;
                arr_wmask = '1;
                arr_addr  = init_addr_q;
                wr_data   = '0;
                if (init_addr_q == LAST_ADDR) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Every accepted read owns a buffer slot until it is popped.
                req_ready = (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || pop;
                accept    = req_valid && req_ready;
                csb       = !accept;
                web       = !req_we;
            end
        endcase
    end

    always_comb begin
        arr_din = '0;
        rd_data = '0;
        rd_err  = 1'b0;
        for (int i = 0; i < NUM_WMASK; i++) begin
            arr_din[i*LANE_STORE +: WMASK_WIDTH]  = wr_data[i*WMASK_WIDTH +: WMASK_WIDTH];
            rd_data[i*WMASK_WIDTH +: WMASK_WIDTH] = arr_dout[i*LANE_STORE +: WMASK_WIDTH];
`ifdef SRAM_PARITY_EN
            arr_din[i*LANE_STORE + WMASK_WIDTH] =
                lane_parity(LANE_MAX'(wr_data[i*WMASK_WIDTH +: WMASK_WIDTH]));
            rd_err = rd_err | (arr_dout[i*LANE_STORE + WMASK_WIDTH] !=
                lane_parity(LANE_MAX'(arr_dout[i*LANE_STORE +: WMASK_WIDTH])));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            init_addr_q    <= '0;
            inflight_q     <= 1'b0;
            count_q        <= 2'd0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_err_q[0]  <= 1'b0;
            fifo_err_q[1]  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= accept && !req_we;
            if (state_q == ST_INIT) init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
            if (pop && count_q != 2'd0) begin
                fifo_data_q[0] <= fifo_data_q[1];
                fifo_err_q[0]  <= fifo_err_q[1];
                if (inflight_q) begin
                    fifo_data_q[count_q == 2'd2] <= rd_data;
                    fifo_err_q[count_q == 2'd2]  <= rd_err;
                end else begin
                    count_q <= count_q - 2'd1;
                end
            end else if (!pop && inflight_q) begin
                fifo_data_q[count_q[0]] <= rd_data;
                fifo_err_q[count_q[0]]  <= rd_err;
                count_q <= count_q + 2'd1;
            end
        end
    end

    sram_1rw_array #(
        .WORD_WIDTH (STORE_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .NUM_LANES  (NUM_WMASK)
    ) u_array (
        .clk0   (clk),
        .csb0   (csb),
        .web0   (web),
        .wmask0 (arr_wmask),
        .addr0  (arr_addr),
        .din0   (arr_din),
        .dout0  (arr_dout)
    );

endmodule
